// File: rtl/escaner_pkg.sv
// escaner_pkg
//   Shared definitions for the 4-digit display scanner.
//   - N_DIG       : number of multiplexed digits
//   - ANODOS_OFF  : active-low anode pattern with every digit dark
//   - estado_t    : scanner state (idle / blanking / showing)
//   - anodo_activo: active-low one-hot anode pattern for a digit index
package escaner_pkg;

    localparam int         N_DIG      = 4;
    localparam logic [3:0] ANODOS_OFF = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } estado_t;

    function automatic logic [3:0] anodo_activo(input logic [1:0] sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/escaner_display_siguiente_digito.sv
// siguiente_digito
//   Combinational round-robin search for the next enabled digit.
//   Candidates are examined in the order idx+1, idx+2, idx+3, idx (mod 4),
//   so with i_idx = 3 the result is the lowest set bit of the mask.
//   Ports:
//     i_idx   in  2  current digit index
//     i_mask  in  4  per-digit enable mask
//     o_idx   out 2  next enabled index (i_idx when the mask is empty)
//     o_valid out 1  1 when at least one digit is enabled
module siguiente_digito
    import escaner_pkg::*;
(
    input  logic [1:0]       i_idx,
    input  logic [N_DIG-1:0] i_mask,
    output logic [1:0]       o_idx,
    output logic             o_valid
);

    logic [N_DIG-1:0][1:0] cand;
    logic [N_DIG-1:0]      hit;

    // cand[k] is the index k+1 positions after i_idx; the last candidate
    // wraps back onto i_idx itself.
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_cand
        assign cand[gi] = i_idx + 2'(gi + 1);
        assign hit[gi]  = i_mask[cand[gi]];
    end

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        o_idx = i_idx;
        for (int k = N_DIG - 1; k >= 0; k--) begin
            if (hit[k]) begin
                o_idx = cand[k];
            end
        end
    end

    assign o_valid = |i_mask;

endmodule

// File: rtl/escaner_display.sv
// escaner_display
//   Round-robin sequencer for a 4-digit multiplexed 7-segment display.
//   Each slot lasts CLK_DIV cycles: BLANK_CYC cycles with every anode off
//   (anti-ghosting), then the selected digit is driven for the remainder.
//   Digits cleared in i_Mask are skipped.
//   Ports:
//     i_Clk     in  1  system clock, rising edge
//     i_Rst_n   in  1  asynchronous active-low reset
//     i_En      in  1  1 = scanning enabled
//     i_Mask    in  4  per-digit enable (bit k = digit k)
//     o_Sel     out 2  digit multiplexor select
//     o_Anodos  out 4  active-low one-hot anode enables (1111 = all off)
//     o_Blank   out 1  1 while no anode is driven
//     o_Tick    out 1  one-cycle pulse when o_Sel moves to a new slot
module escaner_display
    import escaner_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_En,
    input  logic [3:0] i_Mask,
    output logic [1:0] o_Sel,
    output logic [3:0] o_Anodos,
    output logic       o_Blank,
    output logic       o_Tick
);

    localparam int                CNT_W      = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - BLANK_CYC - 1);

    estado_t          state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [1:0]       sel_q,    sel_d;
    logic [3:0]       anodos_q, anodos_d;
    logic             blank_q,  blank_d;
    logic             tick_q,   tick_d;

    logic [1:0] nxt_idx;
    logic       nxt_valid;
    logic [1:0] low_idx;
    logic       low_valid;
    logic       run;

    // Next enabled digit after the current one.
    siguiente_digito u_siguiente (
        .i_idx   (sel_q),
        .i_mask  (i_Mask),
        .o_idx   (nxt_idx),
        .o_valid (nxt_valid)
    );

    // Starting from index 3 the search lands on the lowest enabled digit.
    siguiente_digito u_primero (
        .i_idx   (2'd3),
        .i_mask  (i_Mask),
        .o_idx   (low_idx),
        .o_valid (low_valid)
    );

    assign run = i_En && nxt_valid;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        anodos_d = ANODOS_OFF;
        blank_d  = 1'b1;
        tick_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_En && low_valid) begin
                    sel_d   = low_idx;
                    cnt_d   = '0;
                    state_d = ST_BLANK;
                end
            end

            ST_BLANK: begin
                if (!run) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == BLANK_LAST) begin
                    cnt_d = '0;
                    if (i_Mask[sel_q]) begin
                        state_d  = ST_SHOW;
                        anodos_d = anodo_activo(sel_q);
                        blank_d  = 1'b0;
                    end else begin
                        // Digit was masked while blanking: never light it,
                        // move on as if it had been masked during SHOW.
                        sel_d   = nxt_idx;
                        tick_d  = 1'b1;
                        state_d = ST_BLANK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SHOW: begin
                if (!run) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (!i_Mask[sel_q] || cnt_q == SHOW_LAST) begin
                    sel_d   = nxt_idx;
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                    state_d = ST_BLANK;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    anodos_d = anodo_activo(sel_q);
                    blank_d  = 1'b0;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= 2'b00;
            anodos_q <= ANODOS_OFF;
            blank_q  <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            anodos_q <= anodos_d;
            blank_q  <= blank_d;
            tick_q   <= tick_d;
        end
    end

    assign o_Sel    = sel_q;
    assign o_Anodos = anodos_q;
    assign o_Blank  = blank_q;
    assign o_Tick   = tick_q;

endmodule

// File: tb/tb_escaner_display.sv
// tb_escaner_display
//   Directed, table-driven check of escaner_display with CLK_DIV=8,
//   BLANK_CYC=2 (slot = tick/blank, blank, 6 show cycles).
module tb_escaner_display;

    logic       i_Clk;
    logic       i_Rst_n;
    logic       i_En;
    logic [3:0] i_Mask;
    logic [1:0] o_Sel;
    logic [3:0] o_Anodos;
    logic       o_Blank;
    logic       o_Tick;

    escaner_display #(
        .CLK_DIV   (8),
        .BLANK_CYC (2)
    ) dut (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_En     (i_En),
        .i_Mask   (i_Mask),
        .o_Sel    (o_Sel),
        .o_Anodos (o_Anodos),
        .o_Blank  (o_Blank),
        .o_Tick   (o_Tick)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic       en;
        logic [3:0] mask;
        int         ncyc;
        logic [1:0] sel;
        logic [3:0] an;
        logic       blank;
        logic       tick;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic void add(input logic en, input logic [3:0] mask, input int ncyc,
                                input logic [1:0] sel, input logic [3:0] an,
                                input logic blank, input logic tick);
        vec_t v;
        v.en = en; v.mask = mask; v.ncyc = ncyc;
        v.sel = sel; v.an = an; v.blank = blank; v.tick = tick;
        vecs.push_back(v);
    endfunction

    // One slot: tick/blank cycle, second blank cycle, six show cycles.
    function automatic void slot(input logic [3:0] mask, input logic [1:0] sel,
                                 input logic [3:0] an);
        add(1'b1, mask, 1, sel, 4'hF, 1'b1, 1'b1);
        add(1'b1, mask, 1, sel, 4'hF, 1'b1, 1'b0);
        add(1'b1, mask, 6, sel, an,   1'b0, 1'b0);
    endfunction

    task automatic check(input string name, input int idx, input logic [3:0] got,
                         input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s vec=%0d t=%0t: got %b expected %b", name, idx, $time, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic [1:0] sel,
                             input logic [3:0] an, input logic blank, input logic tick);
        check({tag, ".sel"},   idx, {2'b00, o_Sel}, {2'b00, sel});
        check({tag, ".anodos"}, idx, o_Anodos, an);
        check({tag, ".blank"}, idx, {3'b000, o_Blank}, {3'b000, blank});
        check({tag, ".tick"},  idx, {3'b000, o_Tick}, {3'b000, tick});
    endtask

    initial begin
        // Idle after reset
        add(1'b0, 4'hF, 2, 2'd0, 4'hF, 1'b1, 1'b0);
        // Full scan 0,1,2,3,0
        add(1'b1, 4'hF, 2, 2'd0, 4'hF, 1'b1, 1'b0);
        add(1'b1, 4'hF, 6, 2'd0, 4'hE, 1'b0, 1'b0);
        slot(4'hF, 2'd1, 4'hD);
        slot(4'hF, 2'd2, 4'hB);
        slot(4'hF, 2'd3, 4'h7);
        add(1'b1, 4'hF, 1, 2'd0, 4'hF, 1'b1, 1'b1);
        add(1'b1, 4'hF, 1, 2'd0, 4'hF, 1'b1, 1'b0);
        // Sparse mask 0101 from here: 2,0,2
        add(1'b1, 4'h5, 6, 2'd0, 4'hE, 1'b0, 1'b0);
        slot(4'h5, 2'd2, 4'hB);
        slot(4'h5, 2'd0, 4'hE);
        slot(4'h5, 2'd2, 4'hB);
        add(1'b1, 4'h5, 1, 2'd0, 4'hF, 1'b1, 1'b1);
        add(1'b1, 4'hF, 1, 2'd0, 4'hF, 1'b1, 1'b0);
        add(1'b1, 4'hF, 6, 2'd0, 4'hE, 1'b0, 1'b0);
        // Mask the active digit (sel 2) on its 3rd show cycle
        slot(4'hF, 2'd1, 4'hD);
        add(1'b1, 4'hF, 1, 2'd2, 4'hF, 1'b1, 1'b1);
        add(1'b1, 4'hF, 1, 2'd2, 4'hF, 1'b1, 1'b0);
        add(1'b1, 4'hF, 3, 2'd2, 4'hB, 1'b0, 1'b0);
        add(1'b1, 4'hB, 1, 2'd3, 4'hF, 1'b1, 1'b1);
        add(1'b1, 4'hB, 1, 2'd3, 4'hF, 1'b1, 1'b0);
        add(1'b1, 4'hB, 6, 2'd3, 4'h7, 1'b0, 1'b0);
        slot(4'hB, 2'd0, 4'hE);
        // Disable during SHOW of sel 1, sel held in IDLE
        add(1'b1, 4'hB, 1, 2'd1, 4'hF, 1'b1, 1'b1);
        add(1'b1, 4'hB, 1, 2'd1, 4'hF, 1'b1, 1'b0);
        add(1'b1, 4'hB, 2, 2'd1, 4'hD, 1'b0, 1'b0);
        add(1'b0, 4'hB, 3, 2'd1, 4'hF, 1'b1, 1'b0);
        // Re-enable with mask 1110: lowest enabled is 1, full blank first
        add(1'b1, 4'hE, 2, 2'd1, 4'hF, 1'b1, 1'b0);
        add(1'b1, 4'hE, 6, 2'd1, 4'hD, 1'b0, 1'b0);
        // Single digit 3: sel stays 3, tick every slot
        slot(4'h8, 2'd3, 4'h7);
        slot(4'h8, 2'd3, 4'h7);
        add(1'b1, 4'h8, 1, 2'd3, 4'hF, 1'b1, 1'b1);
        add(1'b1, 4'h8, 1, 2'd3, 4'hF, 1'b1, 1'b0);
        add(1'b1, 4'h8, 2, 2'd3, 4'h7, 1'b0, 1'b0);
        // Empty mask: idle, all off, no ticks
        add(1'b1, 4'h0, 4, 2'd3, 4'hF, 1'b1, 1'b0);
        // Restart and run into SHOW of sel 1 for the async reset check
        add(1'b1, 4'hF, 2, 2'd0, 4'hF, 1'b1, 1'b0);
        add(1'b1, 4'hF, 6, 2'd0, 4'hE, 1'b0, 1'b0);
        add(1'b1, 4'hF, 1, 2'd1, 4'hF, 1'b1, 1'b1);
        add(1'b1, 4'hF, 1, 2'd1, 4'hF, 1'b1, 1'b0);
        add(1'b1, 4'hF, 2, 2'd1, 4'hD, 1'b0, 1'b0);

        // Reset held across edges
        i_Rst_n = 1'b0;
        i_En    = 1'b0;
        i_Mask  = 4'hF;
        repeat (3) @(posedge i_Clk);
        #1;
        check_all("reset", 0, 2'd0, 4'hF, 1'b1, 1'b0);
        i_Rst_n = 1'b1;

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].ncyc; c++) begin
                i_En   = vecs[i].en;
                i_Mask = vecs[i].mask;
                @(posedge i_Clk);
                #1;
                check_all("vec", i, vecs[i].sel, vecs[i].an, vecs[i].blank, vecs[i].tick);
            end
        end

        // Asynchronous reset mid-SHOW, observed before any clock edge
        #3;
        i_Rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 2'd0, 4'hF, 1'b1, 1'b0);
        @(posedge i_Clk);
        #1;
        check_all("rst_hold", 0, 2'd0, 4'hF, 1'b1, 1'b0);
        i_Rst_n = 1'b1;
        i_En    = 1'b0;
        @(posedge i_Clk);
        #1;
        check_all("post_rst", 0, 2'd0, 4'hF, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
